// File: rtl/usb_fs_out_drain_arb.sv
// Round-robin drain arbiter between the OUT PE endpoint read port and NUM_OUT_EPS consumers.
// Latency: eligible -> grant+get next cycle -> byte on rd_* the cycle after (empty-FIFO bypass).
// Backpressure: rd_valid/rd_ready on a 2-entry skid FIFO; gets are throttled so it never overflows.
module usb_fs_out_drain_arb #(
  parameter int NUM_OUT_EPS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_OUT_EPS-1:0] req,
  output logic [NUM_OUT_EPS-1:0] grant,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic                   rd_last,
  output logic [3:0]             rd_ep,
  output logic                   rd_setup,
  output logic                   rd_abort,
  input  logic [NUM_OUT_EPS-1:0] out_ep_data_avail,
  input  logic [NUM_OUT_EPS-1:0] out_ep_setup,
  output logic [NUM_OUT_EPS-1:0] out_ep_data_get,
  input  logic [7:0]             out_ep_data
);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                 state;
  logic [3:0]             rr_ptr;
  logic [3:0]             ep;
  logic                   setup_r;
  logic                   abort_r;
  logic                   inflight;

  // skid FIFO storage: {last, data}
  logic [8:0]             mem [2];
  logic                   wp;
  logic                   rp;
  logic [1:0]             cnt;

  logic [NUM_OUT_EPS-1:0] elig;
  logic                   pick_vld;
  logic [3:0]             pick_idx;
  logic [NUM_OUT_EPS-1:0] pick_oh;
  logic                   pick_setup;
  logic [3:0]             rr_next;
  logic                   hi_vld;
  logic [3:0]             hi_idx;
  logic [3:0]             lo_idx;

  logic                   avail_ep;
  logic                   pop;
  logic                   push;
  logic                   get_en;
  logic [8:0]             head;
  logic [8:0]             cap;

  // Round-robin pick: lowest eligible index at/after rr_ptr, else lowest eligible overall
  always_comb begin
    elig     = req & out_ep_data_avail;
    pick_vld = 1'b0;
    hi_vld   = 1'b0;
    hi_idx   = 4'd0;
    lo_idx   = 4'd0;
    pick_oh  = '0;
    for (int i = NUM_OUT_EPS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        pick_vld = 1'b1;
        lo_idx   = 4'(i);
        if (i >= int'(rr_ptr)) begin
          hi_vld = 1'b1;
          hi_idx = 4'(i);
        end
      end
    end
    pick_idx = hi_vld ? hi_idx : lo_idx;
    for (int i = 0; i < NUM_OUT_EPS; i++) begin
      pick_oh[i] = (4'(i) == pick_idx);
    end
    pick_setup = |(out_ep_setup & pick_oh);
    rr_next    = (pick_idx == 4'(NUM_OUT_EPS - 1)) ? 4'd0 : pick_idx + 4'd1;
  end

  // grant is one-hot of ep, so it doubles as the endpoint select mask
  assign avail_ep = |(out_ep_data_avail & grant);
  assign push     = inflight;
  assign pop      = rd_valid & rd_ready;
  // the byte arriving this cycle is last if the PE has nothing more behind it
  assign cap      = {~avail_ep, out_ep_data};

  // Only fetch when the byte can land: queued + in flight - leaving must stay below 2
  assign get_en = (state == STREAM) & avail_ep &
                  (({1'b0, cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  assign out_ep_data_get = grant & {NUM_OUT_EPS{get_en}};

  // Empty FIFO presents the in-flight byte directly so the first byte costs no extra cycle
  assign head     = (cnt != 2'd0) ? mem[rp] : cap;
  assign rd_valid = (cnt != 2'd0) | inflight;
  assign rd_data  = rd_valid ? head[7:0] : 8'd0;
  assign rd_last  = rd_valid & head[8];
  assign rd_ep    = ep;
  assign rd_setup = setup_r;
  assign rd_abort = abort_r;

  // FIFO storage write; a bypassed byte is also written but its slot is consumed at once
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= cap;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Arbitration / packet FSM with registered grant, endpoint, setup and abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      ep       <= 4'd0;
      setup_r  <= 1'b0;
      abort_r  <= 1'b0;
      rr_ptr   <= 4'd0;
      inflight <= 1'b0;
    end else begin
      abort_r  <= 1'b0;
      inflight <= get_en;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            ep      <= pick_idx;
            grant   <= pick_oh;
            setup_r <= pick_setup;
            rr_ptr  <= rr_next;
            state   <= STREAM;
          end
        end
        STREAM: begin
          // avail low with a capture pending means that capture is the last byte;
          // avail low with nothing pending means the packet was pulled from under us
          if (!avail_ep) begin
            if (!inflight) abort_r <= 1'b1;
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if ((cnt == 2'd0) || ((cnt == 2'd1) && pop)) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_fs_out_drain_arb.sv
// Directed bench for usb_fs_out_drain_arb with a 3-endpoint OUT PE model.
// PE model answers a get with the next byte one cycle later; avail = bytes remaining.
// Consumer side driven by a per-cycle rd_ready value; popped bytes go to a queue.
module tb_usb_fs_out_drain_arb;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [7:0]   rd_data;
  logic         rd_valid;
  logic         rd_ready;
  logic         rd_last;
  logic [3:0]   rd_ep;
  logic         rd_setup;
  logic         rd_abort;
  logic [N-1:0] avail;
  logic [N-1:0] setup;
  logic [N-1:0] get;
  logic [7:0]   pe_data;

  always #5 clk = ~clk;

  usb_fs_out_drain_arb #(.NUM_OUT_EPS(N)) u_dut (
    .clk               (clk),
    .reset             (reset),
    .req               (req),
    .grant             (grant),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .rd_ready          (rd_ready),
    .rd_last           (rd_last),
    .rd_ep             (rd_ep),
    .rd_setup          (rd_setup),
    .rd_abort          (rd_abort),
    .out_ep_data_avail (avail),
    .out_ep_setup      (setup),
    .out_ep_data_get   (get),
    .out_ep_data       (pe_data)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [7:0]  pkt [N][16];
  int          idx [N];
  int          rem [N];
  logic [13:0] rx_q [$];   // {setup, ep[3:0], last, data}
  int          gets_total;
  int          pops_total;
  logic        ready_nxt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic upd_avail();
    for (int i = 0; i < N; i++) avail[i] = (rem[i] > 0);
  endtask

  task automatic load(input int e, input int len, input logic [7:0] base, input logic [7:0] stp);
    for (int j = 0; j < len; j++) pkt[e][j] = base + stp * 8'(j);
    idx[e] = 0;
    rem[e] = len;
    upd_avail();
  endtask

  // One clock: record what the DUT does at this edge, then advance the PE model
  task automatic tick();
    logic [N-1:0] g;
    logic         p;
    g = get;
    p = rd_valid & rd_ready;
    if (p) begin
      rx_q.push_back({rd_setup, rd_ep, rd_last, rd_data});
      pops_total++;
    end
    if (|g) gets_total++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (g[i] && rem[i] > 0) begin
        pe_data = pkt[i][idx[i]];
        idx[i]++;
        rem[i]--;
      end
    end
    rd_ready = ready_nxt;
    upd_avail();
    @(negedge clk);
  endtask

  logic [2:0] exp_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  int         exp_ep  [4] = '{0, 1, 2, 0};
  int         e1_get  [7] = '{0, 1, 1, 1, 0, 0, 0};
  int         e1_vld  [7] = '{0, 0, 1, 1, 1, 0, 0};
  int         e1_last [7] = '{0, 0, 0, 0, 1, 0, 0};
  int         e1_gnt  [7] = '{0, 1, 1, 1, 1, 1, 0};
  logic [7:0] e1_dat  [7] = '{8'h00, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00};

  initial begin
    int k, gap, maxocc, viol, occ, bad, nset, aborts;
    logic [N-1:0] prev;
    logic pnow;

    reset = 1'b1; req = '0; setup = '0; rd_ready = 1'b0; ready_nxt = 1'b0; pe_data = 8'h00;
    gets_total = 0; pops_total = 0;
    for (int i = 0; i < N; i++) begin idx[i] = 0; rem[i] = 0; end
    upd_avail();
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_get", get, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_last", rd_last, 0);
    check("rst_ep", rd_ep, 0);
    check("rst_setup", rd_setup, 0);
    check("rst_abort", rd_abort, 0);
    reset = 1'b0;

    // round-robin across three busy endpoints, ep0 refilled for a second packet
    load(0, 2, 8'h30, 8'h01); load(1, 2, 8'h40, 8'h01); load(2, 2, 8'h50, 8'h01);
    req = 3'b111; ready_nxt = 1'b1; rd_ready = 1'b1; rx_q.delete();
    #1;
    k = 0; gap = 0; prev = '0;
    for (int c = 0; c < 80 && !(k == 4 && grant == '0); c++) begin
      if (grant != '0 && prev == '0 && k < 4) begin
        check($sformatf("t2_grant%0d", k), grant, exp_seq[k]);
        check($sformatf("t2_ep%0d", k), rd_ep, exp_ep[k]);
        if (k > 0) check($sformatf("t2_gap%0d", k), gap, 1);
        k++;
        if (k == 2) load(0, 2, 8'h60, 8'h01);
      end
      if (grant == '0) gap++; else gap = 0;
      prev = grant;
      tick();
    end
    check("t2_grants", k, 4);
    check("t2_bytes", rx_q.size(), 8);

    // single 3-byte packet, cycle-exact; req dropped mid-packet is ignored
    load(0, 3, 8'hA1, 8'h11);
    req = 3'b001; rx_q.delete();
    #1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) tick();
      check($sformatf("t1_get_c%0d", c), get, e1_get[c]);
      check($sformatf("t1_vld_c%0d", c), rd_valid, e1_vld[c]);
      check($sformatf("t1_last_c%0d", c), rd_last, e1_last[c]);
      check($sformatf("t1_grant_c%0d", c), grant, e1_gnt[c]);
      check($sformatf("t1_data_c%0d", c), rd_data, e1_dat[c]);
      if (c == 2) req = 3'b000;
    end

    // backpressure: rd_ready 1,0,0 repeating over an 8-byte packet
    load(1, 8, 8'h10, 8'h01);
    req = 3'b010; rx_q.delete(); gets_total = 0; pops_total = 0; maxocc = 0; viol = 0;
    #1;
    for (int c = 0; c < 120 && !(rx_q.size() == 8 && grant == '0); c++) begin
      occ  = gets_total - pops_total;
      pnow = rd_valid & rd_ready;
      if (occ > maxocc) maxocc = occ;
      if ((occ - int'(pnow)) >= 2 && get != '0) viol++;
      ready_nxt = ((c + 1) % 3 == 0);
      tick();
    end
    check("t3_occ_le2", (maxocc <= 2), 1);
    check("t3_get_when_full", viol, 0);
    check("t3_count", rx_q.size(), 8);
    bad = 0;
    foreach (rx_q[j]) begin
      if (rx_q[j][7:0] !== 8'h10 + 8'(j)) bad++;
      if (rx_q[j][8] !== (j == 7)) bad++;
      if (rx_q[j][12:9] !== 4'd1) bad++;
    end
    check("t3_stream", bad, 0);
    ready_nxt = 1'b1; rd_ready = 1'b1;

    // SETUP packet on ep0; setup input withdrawn after grant, flag must stay latched
    load(0, 8, 8'h20, 8'h01);
    req = 3'b001; setup = 3'b001; rx_q.delete();
    #1;
    tick(); tick();
    setup = 3'b000;
    for (int c = 0; c < 40 && !(rx_q.size() == 8 && grant == '0); c++) tick();
    check("t4_count", rx_q.size(), 8);
    nset = 0; bad = 0;
    foreach (rx_q[j]) begin
      if (rx_q[j][13]) nset++;
      if (rx_q[j][12:9] !== 4'd0) bad++;
      if (rx_q[j][7:0] !== 8'h20 + 8'(j)) bad++;
    end
    check("t4_setup", nset, 8);
    check("t4_ep_data", bad, 0);

    // endpoint reset mid-stream with FIFO full and nothing in flight
    load(2, 8, 8'h50, 8'h01);
    req = 3'b100; ready_nxt = 1'b0; rd_ready = 1'b0; rx_q.delete();
    #1;
    repeat (6) tick();
    check("t5_full_vld", rd_valid, 1);
    check("t5_get_full", get, 0);
    rem[2] = 0; upd_avail();
    check("t5_abort_pre", rd_abort, 0);
    tick();
    check("t5_abort", rd_abort, 1);
    ready_nxt = 1'b1;
    tick();
    check("t5_abort_post", rd_abort, 0);
    aborts = 0;
    for (int c = 0; c < 20 && grant != '0; c++) begin
      if (rd_abort) aborts++;
      tick();
    end
    check("t5_abort_extra", aborts, 0);
    check("t5_grant_end", grant, 0);
    check("t5_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("t5_b0", rx_q[0][8:0], 9'h050);
      check("t5_b1", rx_q[1][8:0], 9'h051);
    end

    // async reset with two bytes queued, then rr restarts from 0
    load(1, 8, 8'h70, 8'h01);
    req = 3'b010; ready_nxt = 1'b0; rd_ready = 1'b0; rx_q.delete();
    #1;
    repeat (4) tick();
    check("t6_vld_pre", rd_valid, 1);
    check("t6_ep_pre", rd_ep, 1);
    reset = 1'b1;
    #1;
    check("t6_grant", grant, 0);
    check("t6_get", get, 0);
    check("t6_vld", rd_valid, 0);
    check("t6_last", rd_last, 0);
    check("t6_ep", rd_ep, 0);
    check("t6_setup", rd_setup, 0);
    check("t6_abort", rd_abort, 0);
    check("t6_data", rd_data, 0);
    for (int i = 0; i < N; i++) begin idx[i] = 0; rem[i] = 0; end
    upd_avail(); req = '0;
    tick();
    reset = 1'b0;
    load(1, 3, 8'h80, 8'h01); load(2, 3, 8'h90, 8'h01);
    req = 3'b110; ready_nxt = 1'b1; rd_ready = 1'b1;
    #1;
    check("t6_idle", grant, 0);
    tick();
    check("t6_rr_grant", grant, 3'b010);
    check("t6_rr_ep", rd_ep, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
